cpu_regfile: RTL

- General-purpose register file: the storage end of the decode stage's register read interface (`reg_raddr*` → `reg*_i`) and the sink of write-back requests (`RegWriteReq_t`).
- 32 × 32-bit registers, four combinational read ports (two per issue slot), two synchronous write ports (write-back of pipe A and pipe B).
- Same-cycle write-to-read bypass, so decode never sees stale data for a value being written back this cycle.

---
 rtl/cpu_regfile.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cpu_regfile.sv
// cpu_regfile: 32 x 32-bit general-purpose register file.
// Four combinational read ports with same-cycle write-back bypass,
// two synchronous write ports (pipe A older, pipe B younger), and a
// registered, non-bypassed debug read port. Register 0 is hardwired to 0.

// One read port: zero-register check, B-over-A bypass, then storage.
module cpu_regfile_rdport #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          rst_n_i,
  input  logic [AW-1:0] raddr_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          wa_we_i,
  input  logic [AW-1:0] wa_waddr_i,
  input  logic [DW-1:0] wa_wdata_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_waddr_i,
  input  logic [DW-1:0] wb_wdata_i,
  output logic [DW-1:0] rdata_o
);

  // Priority mux; output held at 0 for the whole reset window.
  always_comb begin
    rdata_o = mem_rdata_i;
    if (!rst_n_i || raddr_i == '0)
      rdata_o = '0;
    else if (wb_we_i && wb_waddr_i == raddr_i)
      rdata_o = wb_wdata_i;
    else if (wa_we_i && wa_waddr_i == raddr_i)
      rdata_o = wa_wdata_i;
  end

endmodule

module cpu_regfile #(
  parameter  int REG_NUM    = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int AW         = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // write-back request, pipe A (older instruction)
  input  logic                  wr_a_we,
  input  logic [AW-1:0]         wr_a_waddr,
  input  logic [DATA_WIDTH-1:0] wr_a_wdata,
  // write-back request, pipe B (younger instruction)
  input  logic                  wr_b_we,
  input  logic [AW-1:0]         wr_b_waddr,
  input  logic [DATA_WIDTH-1:0] wr_b_wdata,
  input  logic [AW-1:0]         raddr1,
  input  logic [AW-1:0]         raddr2,
  input  logic [AW-1:0]         raddr3,
  input  logic [AW-1:0]         raddr4,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic [DATA_WIDTH-1:0] rdata3,
  output logic [DATA_WIDTH-1:0] rdata4,
  input  logic [AW-1:0]         dbg_raddr,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);

  localparam int NUM_RD = 4;

  // Only registers 1..REG_NUM-1 are stored.
  logic [REG_NUM-1:1][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [REG_NUM-1:0][DATA_WIDTH-1:0] mem_view;
  logic [DATA_WIDTH-1:0]              dbg_rdata_q, dbg_rdata_d;

  logic [NUM_RD-1:0][AW-1:0]          raddr_v;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rdata_v;

  // Full-address view of storage with entry 0 tied to zero.
  always_comb begin
    mem_view                = '0;
    mem_view[REG_NUM-1:1]   = regs_q;
  end

  // Next-state storage: B is applied after A so B wins an address clash.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < REG_NUM; i++) begin
      if (wr_a_we && wr_a_waddr == AW'(i)) regs_d[i] = wr_a_wdata;
      if (wr_b_we && wr_b_waddr == AW'(i)) regs_d[i] = wr_b_wdata;
    end
  end

  // Debug read sees pre-write storage; entry 0 of the view covers reg0.
  always_comb begin
    dbg_rdata_d = mem_view[dbg_raddr];
  end

  // Storage and debug register; async clear, writes ignored in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      dbg_rdata_q <= '0;
    end else begin
      regs_q      <= regs_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_rdata = dbg_rdata_q;

  assign raddr_v = {raddr4, raddr3, raddr2, raddr1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    cpu_regfile_rdport #(
      .AW (AW),
      .DW (DATA_WIDTH)
    ) u_rd (
      .rst_n_i     (rst_n),
      .raddr_i     (raddr_v[p]),
      .mem_rdata_i (mem_view[raddr_v[p]]),
      .wa_we_i     (wr_a_we),
      .wa_waddr_i  (wr_a_waddr),
      .wa_wdata_i  (wr_a_wdata),
      .wb_we_i     (wr_b_we),
      .wb_waddr_i  (wr_b_waddr),
      .wb_wdata_i  (wr_b_wdata),
      .rdata_o     (rdata_v[p])
    );
  end

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];
  assign rdata3 = rdata_v[2];
  assign rdata4 = rdata_v[3];

endmodule
